// File: rtl/svec_d3s_pkg.sv
// Shared register map, CR bit positions and acquisition FSM encoding for the
// SVEC D3S ADC acquisition node.
package svec_d3s_pkg;

  localparam logic [1:0] c_ACQ_CR   = 2'd0;
  localparam logic [1:0] c_ACQ_ADDR = 2'd1;
  localparam logic [1:0] c_ACQ_DATA = 2'd2;

  localparam int c_ACQ_CR_START = 0;
  localparam int c_ACQ_CR_READY = 1;
  localparam int c_ACQ_CR_BUSY  = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACQ  = 2'd1,
    DONE = 2'd2
  } t_acq_state;

  // START is a write-1 pulse, so it always reads back as 0.
  function automatic logic [31:0] cr_word(input logic ready, input logic busy);
    logic [31:0] w;
    w = '0;
    w[c_ACQ_CR_READY] = ready;
    w[c_ACQ_CR_BUSY]  = busy;
    return w;
  endfunction

endpackage

// File: rtl/d3s_acq_ram.sv
// Simple dual-port sample buffer: one synchronous write port and one
// synchronous read port on a single clock.
module d3s_acq_ram #(
  parameter int g_size       = 1024,
  parameter int g_data_width = 16
) (
  input  logic                       clk_125m_i,
  input  logic                       we,
  input  logic [$clog2(g_size)-1:0]  waddr,
  input  logic [g_data_width-1:0]    wdata,
  input  logic [$clog2(g_size)-1:0]  raddr,
  output logic [g_data_width-1:0]    rdata
);

  logic [g_data_width-1:0] mem [g_size];

  // Read-during-write to the same address returns the old contents.
  always_ff @(posedge clk_125m_i) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/svec_top.sv
// Register and buffer core of the SVEC D3S acquisition node: Wishbone classic
// slave decode, ACQ CSRs, acquisition FSM and the sample buffer.
module svec_top
  import svec_d3s_pkg::*;
#(
  parameter int g_size       = 1024,
  parameter int g_data_width = 16,
  parameter int g_simulation = 0
) (
  input  logic                    clk_125m_i,
  input  logic                    rst_a_i,
  input  logic [g_data_width-1:0] adc_data_i,
  input  logic                    adc_valid_i,
  input  logic [1:0]              wb_adr_i,
  input  logic [31:0]             wb_dat_i,
  output logic [31:0]             wb_dat_o,
  input  logic                    wb_cyc_i,
  input  logic                    wb_stb_i,
  input  logic                    wb_we_i,
  output logic                    wb_ack_o,
  output logic                    irq_o,
  output t_acq_state              dbg_state_o
);

  localparam int c_aw = $clog2(g_size);

  t_acq_state              state;
  logic                    ready;
  logic [c_aw-1:0]         wr_ptr;
  logic [c_aw-1:0]         acq_addr;
  logic                    ack;
  logic                    rd_ram;
  logic [31:0]             rd_csr;
  logic [g_data_width-1:0] ram_q;
  logic                    req;
  logic                    wr_req;
  logic                    start;
  logic                    ram_we;
  logic                    unused_bits;

  // Handshake: cyc&stb with ack low is a request; ack follows one cycle later
  // for one cycle only, so a held strobe is acknowledged every second cycle.
  // All register side effects land on the same edge that raises ack.
  assign req    = wb_cyc_i & wb_stb_i & ~ack;
  assign wr_req = req & wb_we_i;
  assign start  = wr_req && (wb_adr_i == c_ACQ_CR) && wb_dat_i[c_ACQ_CR_START];
  // A START in the same cycle as a strobe drops that sample.
  assign ram_we = (state == ACQ) && adc_valid_i && !start;

  assign unused_bits = ^{wb_dat_i[31:c_aw], 1'(g_simulation)};

  always_ff @(posedge clk_125m_i or posedge rst_a_i) begin
    if (rst_a_i) begin
      ack      <= 1'b0;
      rd_ram   <= 1'b0;
      rd_csr   <= '0;
      acq_addr <= '0;
    end else begin
      ack    <= req;
      rd_ram <= 1'b0;
      rd_csr <= '0;
      if (req && !wb_we_i) begin
        case (wb_adr_i)
          c_ACQ_CR:   rd_csr <= cr_word(ready, state == ACQ);
          c_ACQ_ADDR: rd_csr <= 32'(acq_addr);
          c_ACQ_DATA: rd_ram <= 1'b1;
          default:    rd_csr <= '0;
        endcase
      end
      if (wr_req && (wb_adr_i == c_ACQ_ADDR)) acq_addr <= wb_dat_i[c_aw-1:0];
    end
  end

  always_ff @(posedge clk_125m_i or posedge rst_a_i) begin
    if (rst_a_i) begin
      state  <= IDLE;
      ready  <= 1'b0;
      wr_ptr <= '0;
    end else if (start) begin
      state  <= ACQ;
      ready  <= 1'b0;
      wr_ptr <= '0;
    end else begin
      case (state)
        ACQ: begin
          if (adc_valid_i) begin
            wr_ptr <= wr_ptr + 1'b1;
            if (wr_ptr == c_aw'(g_size - 1)) begin
              state <= DONE;
              ready <= 1'b1;
            end
          end
        end
        default: state <= state;
      endcase
    end
  end

  // The RAM always reads ACQ_ADDR; its one-cycle latency lines up with ack
  // because the address is stable for at least one cycle before any request.
  d3s_acq_ram #(
    .g_size       (g_size),
    .g_data_width (g_data_width)
  ) u_ram (
    .clk_125m_i (clk_125m_i),
    .we         (ram_we),
    .waddr      (wr_ptr),
    .wdata      (adc_data_i),
    .raddr      (acq_addr),
    .rdata      (ram_q)
  );

  assign wb_dat_o    = rd_ram ? 32'(ram_q) : rd_csr;
  assign wb_ack_o    = ack;
  assign irq_o       = ready;
  assign dbg_state_o = state;

endmodule

// File: tb/tb_svec_top.sv
// Self-checking bench for svec_top: random sample streams against a buffer
// model, plus CSR, wrap, restart, handshake and reset scenarios.
module tb_svec_top;
  import svec_d3s_pkg::*;

  localparam int N = 1024;

  logic        clk_125m = 1'b0;
  logic        rst_a    = 1'b1;
  logic [15:0] adc_data = '0;
  logic        adc_valid = 1'b0;
  logic [1:0]  wb_adr = '0;
  logic [31:0] wb_dat_w = '0;
  logic [31:0] wb_dat_r;
  logic        wb_cyc = 1'b0;
  logic        wb_stb = 1'b0;
  logic        wb_we  = 1'b0;
  logic        wb_ack;
  logic        irq;
  t_acq_state  dbg_state;

  int tests_run = 0;
  int tests_failed = 0;

  // Reference model: buffer contents and the host-visible acquisition status.
  logic [15:0] ref_mem [N];
  int          ref_cnt   = 0;
  bit          ref_busy  = 0;
  bit          ref_ready = 0;

  svec_top #(.g_size(N), .g_data_width(16), .g_simulation(1)) dut (
    .clk_125m_i  (clk_125m),
    .rst_a_i     (rst_a),
    .adc_data_i  (adc_data),
    .adc_valid_i (adc_valid),
    .wb_adr_i    (wb_adr),
    .wb_dat_i    (wb_dat_w),
    .wb_dat_o    (wb_dat_r),
    .wb_cyc_i    (wb_cyc),
    .wb_stb_i    (wb_stb),
    .wb_we_i     (wb_we),
    .wb_ack_o    (wb_ack),
    .irq_o       (irq),
    .dbg_state_o (dbg_state)
  );

  always #4 clk_125m = ~clk_125m;

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_cr();
    return {29'b0, ref_busy, ref_ready, 1'b0};
  endfunction

  function automatic void model_start();
    ref_busy  = 1;
    ref_ready = 0;
    ref_cnt   = 0;
  endfunction

  task automatic bus_xfer(input logic [1:0] adr, input logic we, input logic [31:0] dat,
                          output logic [31:0] rd);
    bit got;
    got = 0;
    rd  = '0;
    @(negedge clk_125m);
    wb_adr = adr; wb_we = we; wb_dat_w = dat; wb_cyc = 1'b1; wb_stb = 1'b1;
    for (int i = 0; i < 4 && !got; i++) begin
      @(negedge clk_125m);
      if (wb_ack) begin
        got = 1;
        rd  = wb_dat_r;
      end
    end
    wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
    if (!got) check_val("ack_timeout", 32'd0, 32'd1);
    @(negedge clk_125m);
    check_val("ack_width", 32'(wb_ack), 32'd0);
  endtask

  task automatic wb_write(input logic [1:0] adr, input logic [31:0] dat);
    logic [31:0] dummy;
    bus_xfer(adr, 1'b1, dat, dummy);
    if (adr == c_ACQ_CR && dat[0]) model_start();
  endtask

  task automatic wb_read(input logic [1:0] adr, output logic [31:0] rd);
    bus_xfer(adr, 1'b0, 32'd0, rd);
  endtask

  task automatic read_check(input string tag, input logic [1:0] adr, input logic [31:0] exp);
    logic [31:0] rd;
    wb_read(adr, rd);
    check_val(tag, rd, exp);
  endtask

  task automatic check_mem(input string tag, input int addr);
    wb_write(c_ACQ_ADDR, 32'(addr));
    read_check(tag, c_ACQ_DATA, 32'(ref_mem[addr]));
  endtask

  // One strobe per sample, with random idle gaps between strobes.
  task automatic feed(input int n, input bit seq, input logic [15:0] base);
    logic [15:0] d;
    for (int k = 0; k < n; k++) begin
      d = seq ? base + 16'(ref_cnt) : 16'($urandom);
      @(negedge clk_125m);
      adc_valid = 1'b1;
      adc_data  = d;
      if (ref_busy) begin
        ref_mem[ref_cnt] = d;
        ref_cnt++;
        if (ref_cnt == N) begin
          ref_busy  = 0;
          ref_ready = 1;
        end
      end
      @(negedge clk_125m);
      adc_valid = 1'b0;
      repeat ($urandom_range(0, 2)) @(negedge clk_125m);
    end
  endtask

  task automatic poll_ready();
    logic [31:0] rd;
    bit seen;
    seen = 0;
    for (int i = 0; i < 8 && !seen; i++) begin
      wb_read(c_ACQ_CR, rd);
      if (rd[c_ACQ_CR_READY]) seen = 1;
    end
    check_val("poll_ready", 32'(seen), 32'd1);
    check_val("cr_done", rd, 32'h2);
    check_val("irq_done", 32'(irq), 32'd1);
  endtask

  // START written while a sample strobe is high in the very same cycle.
  task automatic start_with_strobe(input logic [15:0] d);
    bit got;
    got = 0;
    @(negedge clk_125m);
    wb_adr = c_ACQ_CR; wb_we = 1'b1; wb_dat_w = 32'h1; wb_cyc = 1'b1; wb_stb = 1'b1;
    adc_valid = 1'b1; adc_data = d;
    for (int i = 0; i < 4 && !got; i++) begin
      @(negedge clk_125m);
      if (wb_ack) got = 1;
    end
    adc_valid = 1'b0;
    wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
    if (!got) check_val("ack_timeout_start", 32'd0, 32'd1);
    model_start();
  endtask

  initial begin
    logic [31:0] rd;
    int acks;
    int a;

    // Reset
    repeat (3) @(negedge clk_125m);
    check_val("rst_dat", wb_dat_r, 32'd0);
    check_val("rst_ack", 32'(wb_ack), 32'd0);
    check_val("rst_irq", 32'(irq), 32'd0);
    rst_a = 1'b0;
    @(negedge clk_125m);
    check_val("rst_state", 32'(dbg_state), 32'(IDLE));
    read_check("rst_cr", c_ACQ_CR, 32'h0);
    read_check("rst_addr", c_ACQ_ADDR, 32'h0);

    // Basic acquisition with a long idle gap mid-run
    wb_write(c_ACQ_CR, 32'h1);
    feed(500, 1'b1, 16'h0000);
    read_check("busy_cr", c_ACQ_CR, exp_cr());
    check_val("busy_irq", 32'(irq), 32'd0);
    check_val("busy_state", 32'(dbg_state), 32'(ACQ));
    repeat (50) @(negedge clk_125m);
    feed(N - 1 - 500, 1'b1, 16'h0000);
    read_check("almost_cr", c_ACQ_CR, 32'h4);
    feed(1, 1'b1, 16'h0000);
    poll_ready();
    for (int i = 0; i < 128; i++) begin
      wb_write(c_ACQ_ADDR, 32'(i));
      read_check("basic_data", c_ACQ_DATA, 32'(i));
    end

    // Samples outside ACQ are not stored
    feed(4, 1'b0, 16'h0);
    check_mem("done_no_write_0", 0);
    check_mem("done_no_write_1023", N - 1);

    // Restart mid-run, with START colliding with a strobe
    wb_write(c_ACQ_CR, 32'h1);
    read_check("restart_cr0", c_ACQ_CR, 32'h4);
    check_val("restart_irq", 32'(irq), 32'd0);
    feed(100, 1'b0, 16'h0);
    start_with_strobe(16'hBEEF);
    feed(N - 1, 1'b1, 16'hA000);
    read_check("restart_almost", c_ACQ_CR, 32'h4);
    feed(1, 1'b1, 16'hA000);
    poll_ready();
    wb_write(c_ACQ_ADDR, 32'd0);
    read_check("restart_data0", c_ACQ_DATA, 32'hA000);
    for (int i = 0; i < 20; i++) check_mem("restart_rand", int'($urandom_range(0, N - 1)));

    // Address wrap, unmapped word, held strobe
    wb_write(c_ACQ_ADDR, 32'(N + 5));
    read_check("wrap_addr", c_ACQ_ADDR, 32'd5);
    read_check("wrap_data", c_ACQ_DATA, 32'(ref_mem[5]));
    wb_write(c_ACQ_ADDR, 32'hFFFF_FFFF);
    read_check("wrap_addr_ones", c_ACQ_ADDR, 32'(N - 1));
    read_check("wrap_data_top", c_ACQ_DATA, 32'(ref_mem[N - 1]));
    wb_write(c_ACQ_ADDR, 32'd5);
    read_check("unmapped_rd", 2'd3, 32'd0);
    wb_write(2'd3, 32'hFFFF_FFFF);
    read_check("unmapped_wr_addr", c_ACQ_ADDR, 32'd5);
    read_check("unmapped_wr_cr", c_ACQ_CR, 32'h2);
    @(negedge clk_125m);
    wb_adr = c_ACQ_CR; wb_we = 1'b0; wb_cyc = 1'b1; wb_stb = 1'b1;
    acks = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk_125m);
      if (wb_ack) acks++;
    end
    wb_cyc = 1'b0; wb_stb = 1'b0;
    check_val("held_stb_acks", 32'(acks), 32'd3);

    // Asynchronous reset during ACQ; RAM contents survive
    wb_write(c_ACQ_CR, 32'h1);
    feed(300, 1'b0, 16'h0);
    @(posedge clk_125m);
    #3 rst_a = 1'b1;
    #1;
    check_val("arst_state", 32'(dbg_state), 32'(IDLE));
    check_val("arst_irq", 32'(irq), 32'd0);
    ref_busy = 0;
    ref_ready = 0;
    @(negedge clk_125m);
    rst_a = 1'b0;
    read_check("arst_cr", c_ACQ_CR, 32'h0);
    read_check("arst_addr", c_ACQ_ADDR, 32'h0);
    feed(5, 1'b0, 16'h0);
    check_mem("arst_keep_0", 0);
    check_mem("arst_keep_700", 700);
    wb_write(c_ACQ_CR, 32'h1);
    feed(N - 1, 1'b0, 16'h0);
    read_check("arst_almost", c_ACQ_CR, 32'h4);
    feed(1, 1'b0, 16'h0);
    poll_ready();
    for (int i = 0; i < 24; i++) begin
      a = int'($urandom_range(0, N - 1));
      check_mem("arst_rand", a);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
